// File: rtl/spike_stats.sv
`default_nettype none
// ============================================================================
// Module   : spike_stats
// Brief    : Windowed spike-rate counter, inter-spike interval meter and
//            burst flag for the Lfi neuron spike train.
// Revision : 1.0 - initial release
// ============================================================================
module spike_stats #(
    parameter int          WINDOW_W  = 16,
    parameter int          COUNT_W   = 8,
    parameter int          ISI_W     = 16,
    parameter logic [15:0] BURST_ISI = 16'd8
) (
    input  logic                clk_i,
    input  logic                reset,
    input  logic                enable_i,
    input  logic                spike_i,
    input  logic [WINDOW_W-1:0] window_len_i,
    output logic [COUNT_W-1:0]  rate_o,
    output logic                rate_valid_o,
    output logic [ISI_W-1:0]    isi_o,
    output logic                isi_valid_o,
    output logic                burst_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [WINDOW_W-1:0] WIN_ONE   = WINDOW_W'(1);
    localparam logic [COUNT_W-1:0]  CNT_ONE   = COUNT_W'(1);
    localparam logic [COUNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [ISI_W-1:0]    ISI_ONE   = ISI_W'(1);
    localparam logic [ISI_W-1:0]    ISI_MAX   = '1;
    localparam logic [ISI_W:0]      BURST_LIM = (ISI_W+1)'(BURST_ISI);

    logic [0:0]          state_q, state_d;
    logic                spike_q;
    logic [WINDOW_W-1:0] win_len_q, win_len_d;
    logic [WINDOW_W-1:0] win_cnt_q, win_cnt_d;
    logic [COUNT_W-1:0]  spk_cnt_q, spk_cnt_d;
    logic                armed_q, armed_d;
    logic [ISI_W-1:0]    isi_cnt_q, isi_cnt_d;
    logic [COUNT_W-1:0]  rate_q, rate_d;
    logic                rate_valid_q, rate_valid_d;
    logic [ISI_W-1:0]    isi_q, isi_d;
    logic                isi_valid_q, isi_valid_d;
    logic                burst_q, burst_d;

    logic ev;
    logic win_last;

    assign ev       = spike_i & ~spike_q;
    assign win_last = (win_cnt_q == (win_len_q - WIN_ONE));

    always_comb begin
        state_d      = state_q;
        win_len_d    = win_len_q;
        win_cnt_d    = win_cnt_q;
        spk_cnt_d    = spk_cnt_q;
        armed_d      = armed_q;
        isi_cnt_d    = isi_cnt_q;
        rate_d       = rate_q;
        rate_valid_d = 1'b0;
        isi_d        = isi_q;
        isi_valid_d  = 1'b0;
        burst_d      = burst_q;

        case (state_q)
            S_IDLE: begin
                if (enable_i && (window_len_i != '0)) begin
                    state_d   = S_RUN;
                    win_len_d = window_len_i;
                    win_cnt_d = '0;
                    spk_cnt_d = '0;
                    armed_d   = 1'b0;
                    isi_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (!enable_i) begin
                    // Partial window is discarded; reported values stay put.
                    state_d   = S_IDLE;
                    win_cnt_d = '0;
                    spk_cnt_d = '0;
                    armed_d   = 1'b0;
                    isi_cnt_d = '0;
                end else begin
                    if (ev) begin
                        if (armed_q) begin
                            isi_d       = isi_cnt_q;
                            isi_valid_d = 1'b1;
                            burst_d     = ({1'b0, isi_cnt_q} <= BURST_LIM) &&
                                          (isi_cnt_q != ISI_MAX);
                        end
                        armed_d   = 1'b1;
                        isi_cnt_d = ISI_ONE;
                    end else if (armed_q && (isi_cnt_q != ISI_MAX)) begin
                        isi_cnt_d = isi_cnt_q + ISI_ONE;
                    end

                    if (win_last) begin
                        rate_d       = (spk_cnt_q == CNT_MAX) ? CNT_MAX
                                                              : spk_cnt_q + COUNT_W'(ev);
                        rate_valid_d = 1'b1;
                        win_cnt_d    = '0;
                        spk_cnt_d    = '0;
                        win_len_d    = window_len_i;
                        if (window_len_i == '0) begin
                            state_d   = S_IDLE;
                            armed_d   = 1'b0;
                            isi_cnt_d = '0;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_ONE;
                        if (ev && (spk_cnt_q != CNT_MAX)) begin
                            spk_cnt_d = spk_cnt_q + CNT_ONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q      <= S_IDLE;
            spike_q      <= 1'b0;
            win_len_q    <= '0;
            win_cnt_q    <= '0;
            spk_cnt_q    <= '0;
            armed_q      <= 1'b0;
            isi_cnt_q    <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
            isi_q        <= '0;
            isi_valid_q  <= 1'b0;
            burst_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            spike_q      <= spike_i;
            win_len_q    <= win_len_d;
            win_cnt_q    <= win_cnt_d;
            spk_cnt_q    <= spk_cnt_d;
            armed_q      <= armed_d;
            isi_cnt_q    <= isi_cnt_d;
            rate_q       <= rate_d;
            rate_valid_q <= rate_valid_d;
            isi_q        <= isi_d;
            isi_valid_q  <= isi_valid_d;
            burst_q      <= burst_d;
        end
    end

    assign rate_o       = rate_q;
    assign rate_valid_o = rate_valid_q;
    assign isi_o        = isi_q;
    assign isi_valid_o  = isi_valid_q;
    assign burst_o      = burst_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_stats.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_stats
// Brief    : Directed bench for spike_stats with an event-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spike_stats;

    localparam int WINDOW_W = 16;
    localparam int COUNT_W  = 4;
    localparam int ISI_W    = 6;
    localparam int CMAX     = 15;
    localparam int IMAX     = 63;
    localparam int BURST    = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable_i;
    logic                spike_i;
    logic [WINDOW_W-1:0] window_len_i;
    logic [COUNT_W-1:0]  rate_o;
    logic                rate_valid_o;
    logic [ISI_W-1:0]    isi_o;
    logic                isi_valid_o;
    logic                burst_o;

    spike_stats #(
        .WINDOW_W (WINDOW_W),
        .COUNT_W  (COUNT_W),
        .ISI_W    (ISI_W),
        .BURST_ISI(16'd8)
    ) dut (
        .clk_i       (clk),
        .reset       (reset),
        .enable_i    (enable_i),
        .spike_i     (spike_i),
        .window_len_i(window_len_i),
        .rate_o      (rate_o),
        .rate_valid_o(rate_valid_o),
        .isi_o       (isi_o),
        .isi_valid_o (isi_valid_o),
        .burst_o     (burst_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc_neg = 0;
    int rate_q[$];
    int rate_t[$];
    int isi_q[$];
    int burst_q[$];

    task automatic cmp(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks events by absolute cycle number and window
    // membership, deriving rate and interval directly from those counts.
    bit m_run = 0, m_prev = 0, m_armed = 0;
    int m_cyc = 0, m_last = 0, m_len = 0, m_pos = 0, m_nev = 0;
    int e_rate = 0, e_isi = 0;
    bit e_rv = 0, e_iv = 0, e_burst = 0;

    always @(posedge clk) begin : model
        bit ev;
        int gap;
        ev   = spike_i && !m_prev;
        e_rv = 0;
        e_iv = 0;
        if (reset) begin
            m_run = 0; m_prev = 0; m_armed = 0;
            e_rate = 0; e_isi = 0; e_burst = 0;
        end else begin
            if (!m_run) begin
                if (enable_i && window_len_i != 0) begin
                    m_run = 1; m_len = int'(window_len_i);
                    m_pos = 0; m_nev = 0; m_armed = 0;
                end
            end else if (!enable_i) begin
                m_run = 0;
            end else begin
                if (ev) begin
                    m_nev++;
                    if (m_armed) begin
                        gap     = m_cyc - m_last;
                        e_isi   = (gap > IMAX) ? IMAX : gap;
                        e_burst = (gap <= BURST) && (gap < IMAX);
                        e_iv    = 1;
                    end
                    m_armed = 1;
                    m_last  = m_cyc;
                end
                m_pos++;
                if (m_pos == m_len) begin
                    e_rate = (m_nev > CMAX) ? CMAX : m_nev;
                    e_rv   = 1;
                    m_nev  = 0;
                    m_pos  = 0;
                    m_len  = int'(window_len_i);
                    if (m_len == 0) m_run = 0;
                end
            end
            m_prev = spike_i;
        end
        m_cyc++;
    end

    always @(negedge clk) begin : compare
        cyc_neg++;
        cmp("rate_o",       int'(rate_o),       e_rate);
        cmp("rate_valid_o", int'(rate_valid_o), int'(e_rv));
        cmp("isi_o",        int'(isi_o),        e_isi);
        cmp("isi_valid_o",  int'(isi_valid_o),  int'(e_iv));
        cmp("burst_o",      int'(burst_o),      int'(e_burst));
        if (rate_valid_o) begin
            rate_q.push_back(int'(rate_o));
            rate_t.push_back(cyc_neg);
        end
        if (isi_valid_o) begin
            isi_q.push_back(int'(isi_o));
            burst_q.push_back(int'(burst_o));
        end
    end

    task automatic go_idle();
        @(negedge clk);
        enable_i = 1'b0;
        spike_i  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rate_q.delete(); rate_t.delete(); isi_q.delete(); burst_q.delete();
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; enable_i = 1'b1; spike_i = 1'b0; window_len_i = 16'd4;

        // Reset holds everything at zero even with enable and spikes present.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            spike_i = ~spike_i;
        end
        #1;
        cmp("reset rate_valid", int'(rate_valid_o), 0);
        cmp("reset isi_o",      int'(isi_o),        0);
        @(negedge clk);
        reset = 1'b0; enable_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            spike_i = ~spike_i;
        end
        settle();
        cmp("idle rate pulses", rate_q.size(), 0);
        cmp("idle isi pulses",  isi_q.size(),  0);
        cmp("idle rate_o",      int'(rate_o),  0);
        cmp("idle burst_o",     int'(burst_o), 0);
        go_idle();

        // Pulses every 10 cycles in a 100-cycle window.
        window_len_i = 16'd100;
        for (int i = 0; i <= 205; i++) begin
            @(negedge clk);
            enable_i = 1'b1;
            spike_i  = (i >= 1) && (i % 10 == 5);
        end
        settle();
        cmp("win reports", rate_q.size(), 2);
        if (rate_q.size() >= 2) begin
            cmp("win rate0", rate_q[0], 10);
            cmp("win rate1", rate_q[1], 10);
            cmp("win period", rate_t[1] - rate_t[0], 100);
        end
        if (isi_q.size() >= 1) begin
            cmp("win isi", isi_q[0], 10);
            cmp("win burst", burst_q[0], 0);
        end else cmp("win isi count", isi_q.size(), 1);
        go_idle();

        // Level spike held for 50 cycles counts once.
        for (int i = 0; i <= 105; i++) begin
            @(negedge clk);
            enable_i = 1'b1;
            spike_i  = (i >= 1) && (i <= 50);
        end
        settle();
        cmp("level reports", rate_q.size(), 1);
        if (rate_q.size() >= 1) cmp("level rate", rate_q[0], 1);
        cmp("level isi pulses", isi_q.size(), 0);
        go_idle();

        // Twenty pulses saturate a 4-bit count.
        for (int i = 0; i <= 105; i++) begin
            @(negedge clk);
            enable_i = 1'b1;
            spike_i  = (i >= 1) && (i <= 80) && (i % 4 == 1);
        end
        settle();
        cmp("sat reports", rate_q.size(), 1);
        if (rate_q.size() >= 1) cmp("sat rate", rate_q[0], 15);
        go_idle();

        // ISI: events at RUN cycles 5, 11, 40 then 130 (saturating gap).
        window_len_i = 16'd1000;
        for (int i = 0; i <= 140; i++) begin
            @(negedge clk);
            enable_i = 1'b1;
            spike_i  = (i == 6) || (i == 12) || (i == 41) || (i == 131);
        end
        settle();
        cmp("isi reports", isi_q.size(), 3);
        if (isi_q.size() >= 3) begin
            cmp("isi first",    isi_q[0],   6);
            cmp("burst first",  burst_q[0], 1);
            cmp("isi second",   isi_q[1],   29);
            cmp("burst second", burst_q[1], 0);
            cmp("isi sat",      isi_q[2],   63);
            cmp("burst sat",    burst_q[2], 0);
        end
        go_idle();

        // Boundary event, mid-window length change, then length 0 stops.
        window_len_i = 16'd16;
        for (int i = 0; i <= 50; i++) begin
            @(negedge clk);
            enable_i = 1'b1;
            spike_i  = (i == 4) || (i == 16) || (i == 20);
            if (i == 8)  window_len_i = 16'd8;
            if (i == 26) window_len_i = 16'd0;
        end
        settle();
        cmp("bound reports", rate_q.size(), 3);
        if (rate_q.size() >= 3) begin
            cmp("bound win1", rate_q[0], 2);
            cmp("bound win2", rate_q[1], 1);
            cmp("bound win3", rate_q[2], 0);
            cmp("bound len8 a", rate_t[1] - rate_t[0], 8);
            cmp("bound len8 b", rate_t[2] - rate_t[1], 8);
        end
        go_idle();

        // Disable halfway through the second window.
        window_len_i = 16'd100;
        for (int i = 0; i <= 260; i++) begin
            @(negedge clk);
            enable_i = (i <= 150);
            spike_i  = (i >= 1) && (i % 10 == 5);
        end
        @(negedge clk);
        spike_i = 1'b0;
        settle();
        cmp("dis reports", rate_q.size(), 1);
        cmp("dis rate held", int'(rate_o), 10);
        isi_q.delete(); burst_q.delete();
        for (int j = 0; j <= 30; j++) begin
            @(negedge clk);
            enable_i = 1'b1;
            spike_i  = (j == 6) || (j == 13);
        end
        settle();
        cmp("reen isi reports", isi_q.size(), 1);
        if (isi_q.size() >= 1) begin
            cmp("reen isi",   isi_q[0],   7);
            cmp("reen burst", burst_q[0], 1);
        end
        go_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
